// File: rtl/pre_analysis_pkg.sv
// Shared constants, FSM encoding and read-tag payload for the AES memory loaders.
package pre_analysis_pkg;

    localparam int unsigned KEY_BASE_ADDR   = 0;
    localparam int unsigned DATA_OFFSET     = 4;
    localparam int unsigned WORDS_PER_BLOCK = 4;
    localparam int unsigned WORD_W          = 32;
    localparam int unsigned BLOCK_W         = 128;
    localparam int unsigned ADDR_W          = 32;
    localparam int unsigned BLK_ADDR_W      = 12;
    localparam int unsigned CNT_W           = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef struct packed {
        logic       valid;
        logic       is_key;
        logic [1:0] idx;
    } rd_tag_t;

endpackage

// File: rtl/pre_analysis_if.sv
// Control and memory-read bus between the AES loader and its requester/memory.
interface pre_analysis_if;
    import pre_analysis_pkg::*;

    logic                  start;
    logic                  load_key;
    logic [BLK_ADDR_W-1:0] block_address;
    logic [WORD_W-1:0]     mem_data_in;
    logic [ADDR_W-1:0]     address;
    logic                  read_enable;
    logic [BLOCK_W-1:0]    key_out;
    logic [BLOCK_W-1:0]    data_out;
    logic                  busy;
    logic                  done;

    modport master (
        output start, load_key, block_address, mem_data_in,
        input  address, read_enable, key_out, data_out, busy, done
    );

    modport slave (
        input  start, load_key, block_address, mem_data_in,
        output address, read_enable, key_out, data_out, busy, done
    );

endinterface

// File: rtl/pre_analysis_read_tag_pipe.sv
// Shift register carrying read tags alongside the memory's read latency.
module read_tag_pipe
    import pre_analysis_pkg::*;
#(
    parameter int unsigned DEPTH = 1
) (
    input  logic    clk,
    input  logic    rst_n,
    input  rd_tag_t tag_i,
    output rd_tag_t tag_o
);

    rd_tag_t stage_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) stage_q[i] <= '0;
        end else begin
            stage_q[0] <= tag_i;
            for (int i = 1; i < int'(DEPTH); i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/pre_analysis.sv
// Loads the AES key (optional) and one plaintext block from word memory,
// one read per cycle, and assembles them into 128-bit outputs.
module pre_analysis #(
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned KEY_BASE     = pre_analysis_pkg::KEY_BASE_ADDR,
    parameter int unsigned DATA_OFFSET  = pre_analysis_pkg::DATA_OFFSET
) (
    input  logic           CLK,
    input  logic           RST_N,
    pre_analysis_if.slave  bus
);
    import pre_analysis_pkg::*;

    state_e                state_q, state_d;
    logic [ADDR_W-1:0]     address_q, address_d;
    logic                  re_q, re_d;
    logic [BLOCK_W-1:0]    key_q, key_d;
    logic [BLOCK_W-1:0]    data_q, data_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  load_key_q, load_key_d;
    logic [BLK_ADDR_W-1:0] blk_q, blk_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    rd_tag_t               tag_q, tag_d;
    rd_tag_t               tag_out;

    logic                  accept_c;
    logic                  sel_lk_c;
    logic [BLK_ADDR_W-1:0] sel_blk_c;
    logic [CNT_W-1:0]      sel_cnt_c;
    logic [CNT_W-1:0]      n_reads_c;
    rd_tag_t               nxt_tag_c;
    logic [ADDR_W-1:0]     nxt_addr_c;

    read_tag_pipe #(.DEPTH(READ_LATENCY)) u_tag_pipe (
        .clk   (CLK),
        .rst_n (RST_N),
        .tag_i (tag_q),
        .tag_o (tag_out)
    );

    // Address and tag of the next read; on acceptance it comes straight from the request.
    always_comb begin
        accept_c  = bus.start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
        sel_lk_c  = accept_c ? bus.load_key      : load_key_q;
        sel_blk_c = accept_c ? bus.block_address : blk_q;
        sel_cnt_c = accept_c ? '0                : cnt_q;
        n_reads_c = load_key_q ? CNT_W'(2 * WORDS_PER_BLOCK) : CNT_W'(WORDS_PER_BLOCK);

        nxt_tag_c        = '0;
        nxt_tag_c.valid  = 1'b1;
        nxt_tag_c.idx    = sel_cnt_c[1:0];
        nxt_tag_c.is_key = sel_lk_c && (sel_cnt_c < CNT_W'(WORDS_PER_BLOCK));
        if (nxt_tag_c.is_key)
            nxt_addr_c = ADDR_W'(KEY_BASE) + ADDR_W'(nxt_tag_c.idx);
        else
            nxt_addr_c = ADDR_W'(sel_blk_c) + ADDR_W'(DATA_OFFSET) + ADDR_W'(nxt_tag_c.idx);
    end

    always_comb begin
        state_d    = state_q;
        address_d  = address_q;
        re_d       = 1'b0;
        key_d      = key_q;
        data_d     = data_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        load_key_d = load_key_q;
        blk_d      = blk_q;
        cnt_d      = cnt_q;
        tag_d      = '0;

        // Returning word lands in its slice as its tag leaves the pipe.
        if (tag_out.valid) begin
            if (tag_out.is_key) key_d[{tag_out.idx, 5'd0} +: WORD_W]  = bus.mem_data_in;
            else                data_d[{tag_out.idx, 5'd0} +: WORD_W] = bus.mem_data_in;
        end

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (accept_c) begin
                    state_d    = ST_ISSUE;
                    load_key_d = bus.load_key;
                    blk_d      = bus.block_address;
                    address_d  = nxt_addr_c;
                    re_d       = 1'b1;
                    tag_d      = nxt_tag_c;
                    cnt_d      = CNT_W'(1);
                    busy_d     = 1'b1;
                end
            end
            ST_ISSUE: begin
                if (cnt_q < n_reads_c) begin
                    address_d = nxt_addr_c;
                    re_d      = 1'b1;
                    tag_d     = nxt_tag_c;
                    cnt_d     = cnt_q + CNT_W'(1);
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Final data word is always the last read issued.
                if (tag_out.valid && !tag_out.is_key && (tag_out.idx == 2'd3)) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= ST_IDLE;
            address_q  <= '0;
            re_q       <= 1'b0;
            key_q      <= '0;
            data_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            load_key_q <= 1'b0;
            blk_q      <= '0;
            cnt_q      <= '0;
            tag_q      <= '0;
        end else begin
            state_q    <= state_d;
            address_q  <= address_d;
            re_q       <= re_d;
            key_q      <= key_d;
            data_q     <= data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            load_key_q <= load_key_d;
            blk_q      <= blk_d;
            cnt_q      <= cnt_d;
            tag_q      <= tag_d;
        end
    end

    assign bus.address     = address_q;
    assign bus.read_enable = re_q;
    assign bus.key_out     = key_q;
    assign bus.data_out    = data_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;

endmodule
